decode_unit: RTL and testbench

//  RV32E decode stage directly downstream of instruction fetch. Accepts {address, instruction} over a

---
 rtl/decode_unit_if.sv | 33 +++
 rtl/decode_unit.sv | 189 ++++++++++++++++++
 tb/tb_decode_unit.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_unit_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle for decode_unit.
// The master side is the surrounding pipeline; the slave side is the decoder.
interface decode_unit_if #(
   parameter int REG_BITS = 4
) ();
   logic                in_valid;
   logic                in_ready;
   logic [31:0]         in_address;
   logic [31:0]         in_instruction;
   logic                out_valid;
   logic                out_ready;
   logic [31:0]         out_address;
   logic [3:0]          out_class;
   logic [REG_BITS-1:0] out_rd;
   logic [REG_BITS-1:0] out_rs1;
   logic [REG_BITS-1:0] out_rs2;
   logic [2:0]          out_funct3;
   logic                out_alt;
   logic [31:0]         out_imm;
   logic                out_illegal;

   modport master (
      output in_valid, in_address, in_instruction, out_ready,
      input  in_ready, out_valid, out_address, out_class, out_rd, out_rs1, out_rs2,
             out_funct3, out_alt, out_imm, out_illegal
   );

   modport slave (
      input  in_valid, in_address, in_instruction, out_ready,
      output in_ready, out_valid, out_address, out_class, out_rd, out_rs1, out_rs2,
             out_funct3, out_alt, out_imm, out_illegal
   );
endinterface

// File: rtl/decode_unit.sv
// RV32E decode stage: combinational decode of the fetched word into a registered
// output packet, with a one-entry skid register of decoded packets for a registered in_ready.
module decode_unit #(
   parameter int REG_BITS    = 4,
   parameter int CHECK_FUNCT = 1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         flush,
   decode_unit_if.slave bus
);
   localparam logic [3:0] CLS_LUI     = 4'd0;
   localparam logic [3:0] CLS_AUIPC   = 4'd1;
   localparam logic [3:0] CLS_JAL     = 4'd2;
   localparam logic [3:0] CLS_JALR    = 4'd3;
   localparam logic [3:0] CLS_BRANCH  = 4'd4;
   localparam logic [3:0] CLS_LOAD    = 4'd5;
   localparam logic [3:0] CLS_STORE   = 4'd6;
   localparam logic [3:0] CLS_OPIMM   = 4'd7;
   localparam logic [3:0] CLS_OP      = 4'd8;
   localparam logic [3:0] CLS_FENCE   = 4'd9;
   localparam logic [3:0] CLS_SYSTEM  = 4'd10;
   localparam logic [3:0] CLS_ILLEGAL = 4'd15;

   typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_t;

   typedef struct packed {
      logic [31:0]         address;
      logic [3:0]          cls;
      logic [REG_BITS-1:0] rd;
      logic [REG_BITS-1:0] rs1;
      logic [REG_BITS-1:0] rs2;
      logic [2:0]          funct3;
      logic                alt;
      logic [31:0]         imm;
      logic                illegal;
   } packet_t;

   localparam int PKT_BITS = $bits(packet_t);

   // A register field is usable only if no bit above REG_BITS-1 is set.
   function automatic logic reg_fits(input logic [4:0] idx);
      reg_fits = ((idx >> REG_BITS) == 5'd0);
   endfunction

   logic [31:0] instr_s;
   logic [2:0]  f3_s;
   logic [6:0]  f7_s;
   logic [3:0]  cls_s;
   fmt_t        fmt_s;
   logic        opcode_ok_s;
   logic        funct_bad_s;
   logic        use_rd_s;
   logic        use_rs1_s;
   logic        use_rs2_s;
   logic        reg_bad_s;
   logic        illegal_s;
   logic [31:0] imm_s;
   packet_t     dec_s;

   packet_t     out_pkt_r;
   packet_t     skid_pkt_r;
   logic        out_valid_r;
   logic        skid_valid_r;
   logic        in_fire_s;
   logic        out_free_s;

   // Opcode class, instruction format and funct-field legality.
   always_comb begin
      instr_s     = bus.in_instruction;
      f3_s        = instr_s[14:12];
      f7_s        = instr_s[31:25];
      cls_s       = CLS_ILLEGAL;
      fmt_s       = FMT_R;
      opcode_ok_s = 1'b0;
      funct_bad_s = 1'b0;
      if (instr_s[1:0] == 2'b11) begin
         opcode_ok_s = 1'b1;
         case (instr_s[6:2])
            5'b01101: begin cls_s = CLS_LUI;    fmt_s = FMT_U; end
            5'b00101: begin cls_s = CLS_AUIPC;  fmt_s = FMT_U; end
            5'b11011: begin cls_s = CLS_JAL;    fmt_s = FMT_J; end
            5'b11001: begin cls_s = CLS_JALR;   fmt_s = FMT_I; end
            5'b11000: begin cls_s = CLS_BRANCH; fmt_s = FMT_B; end
            5'b00000: begin cls_s = CLS_LOAD;   fmt_s = FMT_I; end
            5'b01000: begin cls_s = CLS_STORE;  fmt_s = FMT_S; end
            5'b00100: begin cls_s = CLS_OPIMM;  fmt_s = FMT_I; end
            5'b01100: begin cls_s = CLS_OP;     fmt_s = FMT_R; end
            5'b00011: begin cls_s = CLS_FENCE;  fmt_s = FMT_I; end
            5'b11100: begin cls_s = CLS_SYSTEM; fmt_s = FMT_I; end
            default:  begin cls_s = CLS_ILLEGAL; fmt_s = FMT_R; opcode_ok_s = 1'b0; end
         endcase
      end else begin
         opcode_ok_s = 1'b0;
      end
      case (cls_s)
         CLS_JALR:   funct_bad_s = (f3_s != 3'd0);
         CLS_BRANCH: funct_bad_s = (f3_s == 3'd2) || (f3_s == 3'd3);
         CLS_LOAD:   funct_bad_s = (f3_s == 3'd3) || (f3_s == 3'd6) || (f3_s == 3'd7);
         CLS_STORE:  funct_bad_s = (f3_s > 3'd2);
         CLS_OP:     funct_bad_s = ((f7_s != 7'h00) && (f7_s != 7'h20)) ||
                                   ((f7_s == 7'h20) && (f3_s != 3'd0) && (f3_s != 3'd5));
         CLS_OPIMM:  funct_bad_s = ((f3_s == 3'd1) && (f7_s != 7'h00)) ||
                                   ((f3_s == 3'd5) && (f7_s != 7'h00) && (f7_s != 7'h20));
         default:    funct_bad_s = 1'b0;
      endcase
   end

   // Register usage, immediate extraction and final packet assembly.
   always_comb begin
      use_rd_s  = (fmt_s == FMT_R) || (fmt_s == FMT_I) || (fmt_s == FMT_U) || (fmt_s == FMT_J);
      use_rs1_s = (fmt_s == FMT_R) || (fmt_s == FMT_I) || (fmt_s == FMT_S) || (fmt_s == FMT_B);
      use_rs2_s = (fmt_s == FMT_R) || (fmt_s == FMT_S) || (fmt_s == FMT_B);
      reg_bad_s = (use_rd_s  && !reg_fits(instr_s[11:7]))  ||
                  (use_rs1_s && !reg_fits(instr_s[19:15])) ||
                  (use_rs2_s && !reg_fits(instr_s[24:20]));
      illegal_s = !opcode_ok_s || reg_bad_s || (funct_bad_s && (CHECK_FUNCT != 0));
      case (fmt_s)
         FMT_I:   imm_s = {{20{instr_s[31]}}, instr_s[31:20]};
         FMT_S:   imm_s = {{20{instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
         FMT_B:   imm_s = {{19{instr_s[31]}}, instr_s[31], instr_s[7], instr_s[30:25],
                           instr_s[11:8], 1'b0};
         FMT_U:   imm_s = {instr_s[31:12], 12'd0};
         FMT_J:   imm_s = {{11{instr_s[31]}}, instr_s[31], instr_s[19:12], instr_s[20],
                           instr_s[30:21], 1'b0};
         default: imm_s = 32'd0;
      endcase
      dec_s         = {PKT_BITS{1'b0}};
      dec_s.address = bus.in_address;
      if (illegal_s) begin
         dec_s.cls     = CLS_ILLEGAL;
         dec_s.illegal = 1'b1;
      end else begin
         dec_s.cls     = cls_s;
         dec_s.illegal = 1'b0;
         dec_s.rd      = use_rd_s  ? instr_s[7 +: REG_BITS]  : {REG_BITS{1'b0}};
         dec_s.rs1     = use_rs1_s ? instr_s[15 +: REG_BITS] : {REG_BITS{1'b0}};
         dec_s.rs2     = use_rs2_s ? instr_s[20 +: REG_BITS] : {REG_BITS{1'b0}};
         dec_s.funct3  = ((fmt_s == FMT_U) || (fmt_s == FMT_J)) ? 3'd0 : f3_s;
         dec_s.alt     = ((cls_s == CLS_OP) || ((cls_s == CLS_OPIMM) && (f3_s == 3'd5)))
                         ? instr_s[30] : 1'b0;
         dec_s.imm     = imm_s;
      end
   end

   assign in_fire_s  = bus.in_valid && !skid_valid_r;
   assign out_free_s = !out_valid_r || bus.out_ready;

   // Output and skid registers; the skid only fills while the output is stalled.
   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid_r  <= 1'b0;
         skid_valid_r <= 1'b0;
         out_pkt_r    <= {PKT_BITS{1'b0}};
         skid_pkt_r   <= {PKT_BITS{1'b0}};
      end else if (flush) begin
         out_valid_r  <= 1'b0;
         skid_valid_r <= 1'b0;
      end else if (out_free_s) begin
         if (skid_valid_r) begin
            out_pkt_r    <= skid_pkt_r;
            out_valid_r  <= 1'b1;
            skid_valid_r <= 1'b0;
         end else if (in_fire_s) begin
            out_pkt_r    <= dec_s;
            out_valid_r  <= 1'b1;
         end else begin
            out_valid_r  <= 1'b0;
         end
      end else if (in_fire_s) begin
         skid_pkt_r   <= dec_s;
         skid_valid_r <= 1'b1;
      end else begin
         skid_valid_r <= skid_valid_r;
      end
   end

   assign bus.in_ready    = !skid_valid_r;
   assign bus.out_valid   = out_valid_r;
   assign bus.out_address = out_pkt_r.address;
   assign bus.out_class   = out_pkt_r.cls;
   assign bus.out_rd      = out_pkt_r.rd;
   assign bus.out_rs1     = out_pkt_r.rs1;
   assign bus.out_rs2     = out_pkt_r.rs2;
   assign bus.out_funct3  = out_pkt_r.funct3;
   assign bus.out_alt     = out_pkt_r.alt;
   assign bus.out_imm     = out_pkt_r.imm;
   assign bus.out_illegal = out_pkt_r.illegal;
endmodule

// File: tb/tb_decode_unit.sv
// Scoreboard bench for decode_unit: a reference decoder predicts each accepted packet,
// a negedge monitor compares on every output transfer, directed steps cover stall/flush/reset.
module tb_decode_unit;
   logic clock = 1'b0;
   logic reset = 1'b1;
   logic flush = 1'b0;
   int   tests_run    = 0;
   int   tests_failed = 0;
   logic [87:0] exp_q[$];
   logic [87:0] exp_v;

   decode_unit_if #(.REG_BITS(4)) bus ();
   decode_unit_if #(.REG_BITS(5)) bus5 ();

   decode_unit #(.REG_BITS(4), .CHECK_FUNCT(1)) dut (
      .clock(clock), .reset(reset), .flush(flush), .bus(bus));
   decode_unit #(.REG_BITS(5), .CHECK_FUNCT(1)) dut5 (
      .clock(clock), .reset(reset), .flush(flush), .bus(bus5));

   always #5 clock = ~clock;

   task automatic check_value(input string tag, input logic [87:0] obs, input logic [87:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: {address, imm, class, rd, rs1, rs2, funct3, alt, illegal} with 5-bit reg fields.
   function automatic logic [87:0] ref_decode(input logic [31:0] addr, input logic [31:0] ins,
                                              input int rb);
      logic [2:0] f3;
      logic [6:0] f7;
      logic [3:0] cls;
      logic [31:0] imm;
      logic [4:0] rd, rs1, rs2;
      byte fmt;
      bit bad;
      bit alt;
      f3  = ins[14:12];
      f7  = ins[31:25];
      bad = 1'b0;
      fmt = "R";
      cls = 4'd15;
      case (ins[6:0])
         7'h37: begin cls = 4'd0;  fmt = "U"; end
         7'h17: begin cls = 4'd1;  fmt = "U"; end
         7'h6F: begin cls = 4'd2;  fmt = "J"; end
         7'h67: begin cls = 4'd3;  fmt = "I"; bad = (f3 != 3'd0); end
         7'h63: begin cls = 4'd4;  fmt = "B"; bad = (f3 == 3'd2 || f3 == 3'd3); end
         7'h03: begin cls = 4'd5;  fmt = "I"; bad = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7); end
         7'h23: begin cls = 4'd6;  fmt = "S"; bad = (f3 > 3'd2); end
         7'h13: begin cls = 4'd7;  fmt = "I";
                      bad = (f3 == 3'd1 && f7 != 7'h00) ||
                            (f3 == 3'd5 && !(f7 == 7'h00 || f7 == 7'h20)); end
         7'h33: begin cls = 4'd8;  fmt = "R";
                      bad = !(f7 == 7'h00 || f7 == 7'h20) ||
                            (f7 == 7'h20 && !(f3 == 3'd0 || f3 == 3'd5)); end
         7'h0F: begin cls = 4'd9;  fmt = "I"; end
         7'h73: begin cls = 4'd10; fmt = "I"; end
         default: bad = 1'b1;
      endcase
      rd  = (fmt == "U" || fmt == "J" || fmt == "I" || fmt == "R") ? ins[11:7]  : 5'd0;
      rs1 = (fmt == "I" || fmt == "B" || fmt == "S" || fmt == "R") ? ins[19:15] : 5'd0;
      rs2 = (fmt == "B" || fmt == "S" || fmt == "R")               ? ins[24:20] : 5'd0;
      if (rb < 5) begin
         if (int'(rd) >= (1 << rb) || int'(rs1) >= (1 << rb) || int'(rs2) >= (1 << rb)) bad = 1'b1;
      end
      case (fmt)
         "I": imm = {{20{ins[31]}}, ins[31:20]};
         "S": imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
         "B": imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
         "U": imm = {ins[31:12], 12'h000};
         "J": imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
         default: imm = 32'd0;
      endcase
      alt = (cls == 4'd8 || (cls == 4'd7 && f3 == 3'd5)) ? ins[30] : 1'b0;
      if (fmt == "U" || fmt == "J") f3 = 3'd0;
      if (bad) ref_decode = {addr, 32'd0, 4'd15, 15'd0, 3'd0, 1'b0, 1'b1};
      else     ref_decode = {addr, imm, cls, rd, rs1, rs2, f3, alt, 1'b0};
   endfunction

   function automatic logic [87:0] pack_out();
      pack_out = {bus.out_address, bus.out_imm, bus.out_class, 5'(bus.out_rd), 5'(bus.out_rs1),
                  5'(bus.out_rs2), bus.out_funct3, bus.out_alt, bus.out_illegal};
   endfunction

   // Scoreboard monitor: sampled on the falling edge, ahead of the edge that transfers.
   always @(negedge clock) begin
      if (reset || flush) begin
         exp_q.delete();
      end else begin
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               check_value("unexpected_out", 88'(bus.out_valid), 88'd0);
            end else begin
               exp_v = exp_q.pop_front();
               check_value("packet", pack_out(), exp_v);
            end
         end
         if (bus.in_valid && bus.in_ready)
            exp_q.push_back(ref_decode(bus.in_address, bus.in_instruction, 4));
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] i);
      bus.in_valid       = v;
      bus.in_address     = a;
      bus.in_instruction = i;
   endtask

   logic [31:0] table_v [16] = '{32'h00500093, 32'h40208033, 32'h4020D093, 32'h12345037,
                                 32'h008000EF, 32'h00112223, 32'h00000073, 32'h0000000F,
                                 32'h00000000, 32'h4020C0B3, 32'h00003083, 32'hFFF00067,
                                 32'h00001067, 32'h0000007F, 32'h00A78793, 32'hFE208EE3};

   initial begin
      int budget;
      logic [31:0] addr_v;
      drive(1'b0, 32'd0, 32'd0);
      bus.out_ready       = 1'b0;
      bus5.in_valid       = 1'b0;
      bus5.in_address     = 32'd0;
      bus5.in_instruction = 32'd0;
      bus5.out_ready      = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      @(negedge clock);
      check_value("rst_out_valid", 88'(bus.out_valid), 88'd0);
      check_value("rst_in_ready", 88'(bus.in_ready), 88'd1);
      check_value("rst_data", pack_out(), 88'd0);

      // addi x1,x0,5
      tick();
      bus.out_ready = 1'b1;
      drive(1'b1, 32'h100, 32'h00500093);
      tick();
      drive(1'b0, 32'd0, 32'd0);
      @(negedge clock);
      check_value("t1_valid", 88'(bus.out_valid), 88'd1);
      check_value("t1_class", 88'(bus.out_class), 88'd7);
      check_value("t1_rd", 88'(bus.out_rd), 88'd1);
      check_value("t1_imm", 88'(bus.out_imm), 88'd5);
      check_value("t1_addr", 88'(bus.out_address), 88'h100);

      // x16 is out of range for REG_BITS=4 only
      tick();
      drive(1'b1, 32'h200, 32'h010000B3);
      bus5.in_valid = 1'b1; bus5.in_address = 32'h200; bus5.in_instruction = 32'h010000B3;
      tick();
      drive(1'b0, 32'd0, 32'd0);
      bus5.in_valid = 1'b0;
      @(negedge clock);
      check_value("t2_class", 88'(bus.out_class), 88'd15);
      check_value("t2_illegal", 88'(bus.out_illegal), 88'd1);
      check_value("t2_rs2", 88'(bus.out_rs2), 88'd0);
      check_value("t2_r5_class", 88'(bus5.out_class), 88'd8);
      check_value("t2_r5_rs2", 88'(bus5.out_rs2), 88'd16);
      check_value("t2_r5_illegal", 88'(bus5.out_illegal), 88'd0);

      // beq x1,x2,-4
      tick();
      drive(1'b1, 32'h300, 32'hFE208EE3);
      tick();
      drive(1'b0, 32'd0, 32'd0);
      @(negedge clock);
      check_value("t3_class", 88'(bus.out_class), 88'd4);
      check_value("t3_regs", 88'({bus.out_rd, bus.out_rs1, bus.out_rs2}), 88'h012);
      check_value("t3_imm", 88'(bus.out_imm), 88'hFFFFFFFC);

      // stall fills the skid, then both drain in order
      tick();
      bus.out_ready = 1'b0;
      drive(1'b1, 32'h0, 32'h00500093);
      tick();
      drive(1'b1, 32'h4, 32'h00A00113);
      tick();
      drive(1'b0, 32'd0, 32'd0);
      @(negedge clock);
      check_value("t4_in_ready_full", 88'(bus.in_ready), 88'd0);
      check_value("t4_hold_addr", 88'(bus.out_address), 88'h0);
      tick();
      bus.out_ready = 1'b1;
      tick();
      @(negedge clock);
      check_value("t4_second_valid", 88'(bus.out_valid), 88'd1);
      check_value("t4_second_addr", 88'(bus.out_address), 88'h4);
      check_value("t4_in_ready_after", 88'(bus.in_ready), 88'd1);
      tick();
      @(negedge clock);
      check_value("t4_empty", 88'(bus.out_valid), 88'd0);

      // flush with output and skid full plus a third packet presented
      tick();
      bus.out_ready = 1'b0;
      drive(1'b1, 32'h500, 32'h00500093);
      tick();
      drive(1'b1, 32'h504, 32'h00A00113);
      tick();
      drive(1'b1, 32'h508, 32'h00112223);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      drive(1'b0, 32'd0, 32'd0);
      bus.out_ready = 1'b1;
      @(negedge clock);
      check_value("t5_out_valid", 88'(bus.out_valid), 88'd0);
      check_value("t5_in_ready", 88'(bus.in_ready), 88'd1);
      tick();
      drive(1'b1, 32'h50C, 32'h00500093);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      drive(1'b0, 32'd0, 32'd0);
      repeat (3) tick();
      @(negedge clock);
      check_value("t5_dropped", 88'(bus.out_valid), 88'd0);

      // reset mid-stall
      tick();
      bus.out_ready = 1'b0;
      drive(1'b1, 32'h600, 32'h00500093);
      tick();
      drive(1'b1, 32'h604, 32'h00A00113);
      tick();
      drive(1'b0, 32'd0, 32'd0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clock);
      check_value("t6_out_valid", 88'(bus.out_valid), 88'd0);
      check_value("t6_in_ready", 88'(bus.in_ready), 88'd1);
      check_value("t6_data", pack_out(), 88'd0);
      tick();
      bus.out_ready = 1'b1;
      drive(1'b1, 32'h700, 32'h00A00113);
      tick();
      drive(1'b0, 32'd0, 32'd0);
      @(negedge clock);
      check_value("t6_valid", 88'(bus.out_valid), 88'd1);
      check_value("t6_rd", 88'(bus.out_rd), 88'd2);
      check_value("t6_imm", 88'(bus.out_imm), 88'd10);
      check_value("t6_addr", 88'(bus.out_address), 88'h700);

      // random traffic over the instruction table with random backpressure
      addr_v = 32'h1000;
      for (int n = 0; n < 300; n++) begin
         tick();
         drive(1'($urandom_range(0, 1)), addr_v, table_v[$urandom_range(0, 15)]);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         addr_v = addr_v + 32'd4;
      end
      tick();
      drive(1'b0, 32'd0, 32'd0);
      bus.out_ready = 1'b1;
      budget = 0;
      while (exp_q.size() != 0 && budget < 50) begin
         tick();
         budget++;
      end
      check_value("drain", 88'(exp_q.size()), 88'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
